// File: rtl/alu_share_arbiter.sv
// Two-requester front end for one shared combinational ALU slice.
// A round-robin grant picks one requester while idle. Its operands are
// held on the ALU inputs for LAT settle cycles. The ALU output is then
// captured into a requester-tagged response that waits for the consumer.
module alu_share_arbiter #(
  parameter int N   = 4,
  parameter int OPW = 2,
  parameter int LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  input  logic           req1_valid,
  output logic           req0_ready,
  output logic           req1_ready,
  input  logic [N-1:0]   req0_a,
  input  logic [N-1:0]   req0_b,
  input  logic [N-1:0]   req1_a,
  input  logic [N-1:0]   req1_b,
  input  logic [OPW-1:0] req0_op,
  input  logic [OPW-1:0] req1_op,
  output logic [N-1:0]   alu_a,
  output logic [N-1:0]   alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [N-1:0]   alu_result,
  input  logic           alu_sign,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [N-1:0]   rsp_result,
  output logic           rsp_sign,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  // Settle counter starts at LAT-1 so that EXEC lasts exactly LAT cycles.
  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t         state_r;
  state_t         next_state_s;
  logic           last_grant_r;
  logic [N-1:0]   opa_r;
  logic [N-1:0]   opb_r;
  logic [OPW-1:0] opc_r;
  logic [3:0]     cnt_r;
  logic           rsp_id_r;
  logic [N-1:0]   rsp_result_r;
  logic           rsp_sign_r;
  logic           rsp_valid_r;
  logic           busy_r;
  logic           grant_id_s;
  logic           accept_s;

  // Round-robin grant: on a tie, serve whoever was not served last.
  // Readies are also gated by rst_n so nothing is accepted during reset.
  always_comb begin
    grant_id_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id_s = ~last_grant_r;
    end else if (req1_valid) begin
      grant_id_s = 1'b1;
    end else begin
      grant_id_s = 1'b0;
    end
    accept_s   = (state_r == IDLE) && (req0_valid || req1_valid) && rst_n;
    req0_ready = accept_s && !grant_id_s;
    req1_ready = accept_s && grant_id_s;
  end

  // Next-state logic for the IDLE -> EXEC -> RESP operation cycle.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_state_s = EXEC;
        end else begin
          next_state_s = IDLE;
        end
      end
      EXEC: begin
        if (cnt_r == 4'd0) begin
          next_state_s = RESP;
        end else begin
          next_state_s = EXEC;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = RESP;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State, operand, counter and response registers. Reset aborts any
  // operation in flight, so its response is never presented.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      opa_r        <= {N{1'b0}};
      opb_r        <= {N{1'b0}};
      opc_r        <= {OPW{1'b0}};
      cnt_r        <= 4'd0;
      rsp_id_r     <= 1'b0;
      rsp_result_r <= {N{1'b0}};
      rsp_sign_r   <= 1'b0;
      rsp_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      rsp_valid_r <= (next_state_s == RESP);
      busy_r      <= (next_state_s != IDLE);
      if (accept_s) begin
        opa_r        <= grant_id_s ? req1_a  : req0_a;
        opb_r        <= grant_id_s ? req1_b  : req0_b;
        opc_r        <= grant_id_s ? req1_op : req0_op;
        rsp_id_r     <= grant_id_s;
        last_grant_r <= grant_id_s;
        cnt_r        <= CNT_INIT;
      end else if (state_r == EXEC) begin
        if (cnt_r == 4'd0) begin
          rsp_result_r <= alu_result;
          rsp_sign_r   <= alu_sign;
        end else begin
          cnt_r <= cnt_r - 4'd1;
        end
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign alu_a      = opa_r;
  assign alu_b      = opb_r;
  assign alu_op     = opc_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_id     = rsp_id_r;
  assign rsp_result = rsp_result_r;
  assign rsp_sign   = rsp_sign_r;
  assign busy       = busy_r;

endmodule
